// File: rtl/prefetch_fetcher_pkg.sv
// Shared enums for the core/fetcher handshake plus small helpers used by the prefetching fetcher.
package prefetch_fetcher_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE, CORE_FETCH, CORE_DECODE, CORE_REQUEST,
    CORE_WAIT, CORE_EXECUTE, CORE_UPDATE, CORE_DONE
  } corestate_t;

  typedef enum logic [1:0] {FET_IDLE, FET_CHING, FET_DONE} fetcher_state_t;

  // What the outstanding memory request is for; DROP = stale, data discarded.
  typedef enum logic [1:0] {REQ_PREFETCH, REQ_DEMAND, REQ_DROP} req_kind_t;

  localparam int PERF_W = 16;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/prefetch_fetcher_queue.sv
// prefetch_queue: circular FIFO of {addr, data} prefetched instructions; flush beats push/pop.
module prefetch_queue #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [ADDR_BITS-1:0] push_addr,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  input  logic                 flush,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS-1:0] head_addr,
  output logic [DATA_BITS-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_BITS-1:0] addr_mem [DEPTH];
  logic [DATA_BITS-1:0] data_mem [DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [PW:0]          count;
  logic                 wr_en, rd_en;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign wr_en     = push && !flush && !full;
  assign rd_en     = pop && !flush && !empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction fetcher with a sequential prefetch queue in front of a single-outstanding memory port.
// Optional hit/miss counters built only when PREFETCH_FETCHER_PERF_EN is defined.
module prefetch_fetcher
  import prefetch_fetcher_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  corestate_t           core_state,
  input  logic [ADDR_BITS-1:0] current_pc,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output fetcher_state_t       fetcher_state,
  output logic [DATA_BITS-1:0] instruction,
  output logic [PERF_W-1:0]    perf_hits,
  output logic [PERF_W-1:0]    perf_misses
);
  logic                 q_push, q_pop, q_flush, q_full, q_empty;
  logic [ADDR_BITS-1:0] q_head_addr;
  logic [DATA_BITS-1:0] q_head_data;

  req_kind_t            req_kind;
  logic                 demand_pend, pf_en;
  logic [ADDR_BITS-1:0] demand_addr, next_addr;
  logic                 fetch_req, hit, miss, mem_done, pf_issue;

  assign fetch_req = (fetcher_state == FET_IDLE) && (core_state == CORE_FETCH);
  assign hit       = fetch_req && !q_empty && (q_head_addr == current_pc);
  assign miss      = fetch_req && !hit;
  assign mem_done  = mem_read_valid && mem_read_ready;

  assign q_flush = miss;
  assign q_pop   = hit;
  assign q_push  = mem_done && (req_kind == REQ_PREFETCH) && !miss;

  // Prefetch only with the port idle, so !full already accounts for the in-flight slot.
  assign pf_issue = pf_en && !mem_read_valid && !demand_pend && !q_full &&
                    (fetcher_state != FET_CHING) && !miss;

  prefetch_queue #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_addr (mem_read_address),
    .push_data (mem_read_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .full      (q_full),
    .empty     (q_empty),
    .head_addr (q_head_addr),
    .head_data (q_head_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetcher_state    <= FET_IDLE;
      instruction      <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      req_kind         <= REQ_PREFETCH;
      demand_pend      <= 1'b0;
      demand_addr      <= '0;
      next_addr        <= '0;
      pf_en            <= 1'b0;
    end else begin
      if (mem_done) mem_read_valid <= 1'b0;

      unique case (fetcher_state)
        FET_IDLE: begin
          if (hit) begin
            instruction   <= q_head_data;
            fetcher_state <= FET_DONE;
          end else if (miss) begin
            if (mem_done && mem_read_address == current_pc) begin
              // In-flight request for the demanded pc lands right now: adopt it.
              instruction   <= mem_read_data;
              fetcher_state <= FET_DONE;
              next_addr     <= current_pc + ADDR_BITS'(1);
              pf_en         <= 1'b1;
            end else begin
              fetcher_state <= FET_CHING;
              demand_addr   <= current_pc;
              if (!mem_read_valid) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= current_pc;
                req_kind         <= REQ_DEMAND;
              end else if (mem_done) begin
                demand_pend <= 1'b1;
              end else if (mem_read_address == current_pc) begin
                req_kind <= REQ_DEMAND;
              end else begin
                req_kind    <= REQ_DROP;
                demand_pend <= 1'b1;
              end
            end
          end
        end
        FET_CHING: begin
          if (mem_done && req_kind == REQ_DEMAND) begin
            instruction   <= mem_read_data;
            fetcher_state <= FET_DONE;
            next_addr     <= demand_addr + ADDR_BITS'(1);
            pf_en         <= 1'b1;
          end else if (demand_pend && !mem_read_valid) begin
            mem_read_valid   <= 1'b1;
            mem_read_address <= demand_addr;
            req_kind         <= REQ_DEMAND;
            demand_pend      <= 1'b0;
          end
        end
        FET_DONE: begin
          if (core_state == CORE_DECODE) fetcher_state <= FET_IDLE;
        end
        default: fetcher_state <= FET_IDLE;
      endcase

      if (pf_issue) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= next_addr;
        next_addr        <= next_addr + ADDR_BITS'(1);
        req_kind         <= REQ_PREFETCH;
      end
    end
  end

`ifdef PREFETCH_FETCHER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (hit)  perf_hits   <= sat_inc(perf_hits);
      if (miss) perf_misses <= sat_inc(perf_misses);
    end
  end
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule
